// File: rtl/shf_issue_ctl_pkg.sv
// Shared definitions for the shifter issue/writeback controller.
// Shift-class encodings and default widths.
package shf_issue_ctl_pkg;

    localparam int SHF_DATASIZE = 16;
    localparam int SHF_RADDR    = 4;

    localparam logic [1:0] SHF_CLS_SHIFT = 2'b00;
    localparam logic [1:0] SHF_CLS_ROT   = 2'b01;
    localparam logic [1:0] SHF_CLS_LEFTZ = 2'b10;
    localparam logic [1:0] SHF_CLS_LEFTO = 2'b11;

    // Only the shift and rotate classes consume the Y operand.
    function automatic logic cls_uses_y(input logic [1:0] c);
        return (c == SHF_CLS_SHIFT) || (c == SHF_CLS_ROT);
    endfunction

endpackage

// File: rtl/shf_issue_ctl.sv
// Two-stage (issue E / writeback W) controller for the 16-bit shifter.
// Forwards the W result into E so dependent shifts issue back-to-back.
module shf_issue_ctl
    import shf_issue_ctl_pkg::*;
#(
    parameter int DATASIZE = SHF_DATASIZE,
    parameter int RADDR    = SHF_RADDR
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_cls,
    input  logic [RADDR-1:0]    req_rx,
    input  logic [RADDR-1:0]    req_ry,
    input  logic [RADDR-1:0]    req_rn,
    input  logic                xb_busy,
    output logic [RADDR-1:0]    rf_rd_addr_x,
    output logic [RADDR-1:0]    rf_rd_addr_y,
    input  logic [DATASIZE-1:0] rf_rd_dt_x,
    input  logic [DATASIZE-1:0] rf_rd_dt_y,
    output logic                ps_shf_en,
    output logic [1:0]          ps_shf_cls,
    output logic [DATASIZE-1:0] xb_dtx,
    output logic [DATASIZE-1:0] xb_dty,
    input  logic [DATASIZE-1:0] shf_xb_dt,
    input  logic                shf_ps_sv,
    input  logic                shf_ps_sz,
    output logic                rf_wr_en,
    output logic [RADDR-1:0]    rf_wr_addr,
    output logic [DATASIZE-1:0] rf_wr_dt,
    input  logic                stky_clr,
    output logic                astat_sv,
    output logic                astat_sz,
    output logic                stky_sv
);

    logic             r_w_valid;
    logic [RADDR-1:0] r_w_rn;
    logic             r_astat_sv;
    logic             r_astat_sz;
    logic             r_stky_sv;

    logic w_issue;
    logic w_fwd_x;
    logic w_fwd_y;
    logic w_wb;

    assign req_ready    = ~reset & ~xb_busy;
    assign w_issue      = req_valid & req_ready;
    assign rf_rd_addr_x = req_rx;
    assign rf_rd_addr_y = req_ry;

    // The RF has no write-through, so the W result is bypassed into E.
    assign w_fwd_x = r_w_valid & (r_w_rn == req_rx);
    assign w_fwd_y = r_w_valid & (r_w_rn == req_ry)
                   & cls_uses_y(req_cls);

    // Operand and class drive toward the shifter; idle cycles drive zero.
    always_comb begin
        ps_shf_en  = w_issue;
        ps_shf_cls = SHF_CLS_SHIFT;
        xb_dtx     = '0;
        xb_dty     = '0;
        if (w_issue) begin
            ps_shf_cls = req_cls;
            xb_dtx     = w_fwd_x ? shf_xb_dt : rf_rd_dt_x;
            if (cls_uses_y(req_cls)) begin
                xb_dty = w_fwd_y ? shf_xb_dt : rf_rd_dt_y;
            end
        end
    end

    // E-to-W pipeline register; W never stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_w_valid <= 1'b0;
        end else begin
            r_w_valid <= w_issue;
        end
        r_w_rn <= req_rn;
    end

    // An op sitting in W during reset is dropped.
    assign w_wb       = r_w_valid & ~reset;
    assign rf_wr_en   = w_wb;
    assign rf_wr_addr = r_w_rn;
    assign rf_wr_dt   = shf_xb_dt;

    // Status update at the end of W; a new SV outranks a sticky clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_astat_sv <= 1'b0;
            r_astat_sz <= 1'b0;
            r_stky_sv  <= 1'b0;
        end else begin
            if (r_w_valid) begin
                r_astat_sv <= shf_ps_sv;
                r_astat_sz <= shf_ps_sz;
            end
            r_stky_sv <= (r_stky_sv & ~stky_clr)
                       | (r_w_valid & shf_ps_sv);
        end
    end

    assign astat_sv = r_astat_sv;
    assign astat_sz = r_astat_sz;
    assign stky_sv  = r_stky_sv;

endmodule

// File: tb/tb_shf_issue_ctl.sv
// Bench for shf_issue_ctl with a behavioural shifter and register file.
// Register writes are checked against a scoreboard of expected results.
module tb_shf_issue_ctl;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_cls;
    logic [AW-1:0] req_rx, req_ry, req_rn;
    logic          xb_busy;
    logic [AW-1:0] rf_rd_addr_x, rf_rd_addr_y;
    logic [DW-1:0] rf_rd_dt_x, rf_rd_dt_y;
    logic          ps_shf_en;
    logic [1:0]    ps_shf_cls;
    logic [DW-1:0] xb_dtx, xb_dty;
    logic [DW-1:0] shf_xb_dt;
    logic          shf_ps_sv, shf_ps_sz;
    logic          rf_wr_en;
    logic [AW-1:0] rf_wr_addr;
    logic [DW-1:0] rf_wr_dt;
    logic          stky_clr;
    logic          astat_sv, astat_sz, stky_sv;

    int n_cmp = 0;
    int n_err = 0;

    shf_issue_ctl #(.DATASIZE(DW), .RADDR(AW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cls(req_cls), .req_rx(req_rx),
        .req_ry(req_ry), .req_rn(req_rn),
        .xb_busy(xb_busy),
        .rf_rd_addr_x(rf_rd_addr_x), .rf_rd_addr_y(rf_rd_addr_y),
        .rf_rd_dt_x(rf_rd_dt_x), .rf_rd_dt_y(rf_rd_dt_y),
        .ps_shf_en(ps_shf_en), .ps_shf_cls(ps_shf_cls),
        .xb_dtx(xb_dtx), .xb_dty(xb_dty),
        .shf_xb_dt(shf_xb_dt),
        .shf_ps_sv(shf_ps_sv), .shf_ps_sz(shf_ps_sz),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
        .rf_wr_dt(rf_wr_dt), .stky_clr(stky_clr),
        .astat_sv(astat_sv), .astat_sz(astat_sz),
        .stky_sv(stky_sv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: combinational read, no write-through.
    logic [DW-1:0] rf [16];
    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_dt;

    assign rf_rd_dt_x = rf[rf_rd_addr_x];
    assign rf_rd_dt_y = rf[rf_rd_addr_y];

    always @(posedge clk) begin
        if (pre_en) rf[pre_addr] <= pre_dt;
        if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_dt;
    end

    // Shifter: Y signed amount, + left / - right (arithmetic).
    function automatic logic [17:0] shf_f(input logic [1:0] c,
                                          input logic [15:0] x,
                                          input logic [15:0] y);
        logic [15:0] r;
        logic signed [15:0] t;
        logic sv;
        logic stop;
        int n;
        int cnt;
        r = '0; sv = 1'b0; stop = 1'b0; cnt = 0;
        n = $signed(y);
        case (c)
            2'b00: begin
                if (n > 15) begin
                    r = '0; sv = (x != 0);
                end else if (n >= 0) begin
                    r = x << n;
                    t = $signed(r) >>> n;
                    sv = (t != $signed(x));
                end else if (n < -15) begin
                    r = {16{x[15]}};
                end else begin
                    t = $signed(x) >>> (-n);
                    r = t;
                end
            end
            2'b01: begin
                r = (x << y[3:0]) | (x >> (16 - int'(y[3:0])));
            end
            default: begin
                for (int i = 15; i >= 0; i--) begin
                    if (!stop && (x[i] == c[0])) cnt++;
                    else stop = 1'b1;
                end
                r = 16'(cnt);
                sv = (cnt == 16);
            end
        endcase
        return {sv, (r == 0), r};
    endfunction

    logic [15:0] s_x, s_y;
    logic [1:0]  s_cls;
    logic [17:0] s_out;

    // The shifter's own reset is ~reset (active-low); modelled here.
    always @(posedge clk) begin
        if (reset) begin
            s_x <= '0; s_y <= '0; s_cls <= '0;
        end else if (ps_shf_en) begin
            s_x <= xb_dtx; s_y <= xb_dty; s_cls <= ps_shf_cls;
        end
    end

    assign s_out     = shf_f(s_cls, s_x, s_y);
    assign shf_xb_dt = s_out[15:0];
    assign shf_ps_sz = s_out[16];
    assign shf_ps_sv = s_out[17];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t sb[$];

    // Every RF write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rf_wr_en) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL wr_unexpected: addr %h data %h",
                         rf_wr_addr, rf_wr_dt);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", 32'(rf_wr_addr), 32'(e.addr));
                chk("wr_data", 32'(rf_wr_dt), 32'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        pre_en = 1'b1; pre_addr = a; pre_dt = d;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic drive(input logic [1:0] c, input logic [AW-1:0] x,
                         input logic [AW-1:0] y, input logic [AW-1:0] n);
        req_valid = 1'b1; req_cls = c;
        req_rx = x; req_ry = y; req_rn = n;
    endtask

    task automatic expect_wr(input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
        wr_t e;
        e.addr = a; e.data = d;
        sb.push_back(e);
    endtask

    typedef struct {
        logic [1:0]    cls;
        logic [AW-1:0] rx, ry, rn;
        logic [DW-1:0] xv, yv;
        logic [DW-1:0] dty;
        logic [DW-1:0] res;
        logic          sv, sz;
    } vec_t;

    vec_t vt[6];
    logic exp_stky;

    initial begin
        vt[0] = '{2'b00, 4'd1, 4'd2, 4'd3, 16'hF000, 16'hFFFC,
                  16'hFFFC, 16'hFF00, 1'b0, 1'b0};
        vt[1] = '{2'b00, 4'd1, 4'd2, 4'd3, 16'h4000, 16'h0001,
                  16'h0001, 16'h8000, 1'b1, 1'b0};
        vt[2] = '{2'b01, 4'd1, 4'd2, 4'd4, 16'h8001, 16'h0001,
                  16'h0001, 16'h0003, 1'b0, 1'b0};
        vt[3] = '{2'b00, 4'd1, 4'd2, 4'd4, 16'h0001, 16'hFFFF,
                  16'hFFFF, 16'h0000, 1'b0, 1'b1};
        vt[4] = '{2'b10, 4'd5, 4'd2, 4'd8, 16'h0000, 16'h1234,
                  16'h0000, 16'h0010, 1'b1, 1'b0};
        vt[5] = '{2'b11, 4'd6, 4'd2, 4'd9, 16'hFFA0, 16'h1234,
                  16'h0000, 16'h0009, 1'b0, 1'b0};

        reset = 1'b1; req_valid = 1'b1; req_cls = 2'b00;
        req_rx = '0; req_ry = '0; req_rn = '0;
        xb_busy = 1'b0; stky_clr = 1'b0;
        pre_en = 1'b0; pre_addr = '0; pre_dt = '0;
        exp_stky = 1'b0;

        tick();
        tick();
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_shf_en", 32'(ps_shf_en), 0);
        chk("rst_wr_en", 32'(rf_wr_en), 0);
        chk("rst_flags", {astat_sv, astat_sz, stky_sv}, 0);
        reset = 1'b0; req_valid = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            preload(vt[i].rx, vt[i].xv);
            preload(vt[i].ry, vt[i].yv);
            drive(vt[i].cls, vt[i].rx, vt[i].ry, vt[i].rn);
            expect_wr(vt[i].rn, vt[i].res);
            #1;
            chk("v_en", 32'(ps_shf_en), 1);
            chk("v_cls", 32'(ps_shf_cls), 32'(vt[i].cls));
            chk("v_dtx", 32'(xb_dtx), 32'(vt[i].xv));
            chk("v_dty", 32'(xb_dty), 32'(vt[i].dty));
            tick();
            req_valid = 1'b0;
            tick();
            exp_stky = exp_stky | vt[i].sv;
            chk("v_sv", 32'(astat_sv), 32'(vt[i].sv));
            chk("v_sz", 32'(astat_sz), 32'(vt[i].sz));
            chk("v_stky", 32'(stky_sv), 32'(exp_stky));
        end

        // Back-to-back dependent ops, dual forward, and WAW ordering.
        preload(4'd1, 16'h0001);
        preload(4'd2, 16'h0004);
        preload(4'd3, 16'h5555);
        preload(4'd4, 16'h0003);
        drive(2'b00, 4'd1, 4'd2, 4'd3);
        expect_wr(4'd3, 16'h0010);
        #1;
        chk("f0_dtx", 32'(xb_dtx), 32'h0001);
        tick();
        drive(2'b01, 4'd3, 4'd2, 4'd4);
        expect_wr(4'd4, 16'h0100);
        #1;
        chk("f1_dtx_fwd", 32'(xb_dtx), 32'h0010);
        chk("f1_dty", 32'(xb_dty), 32'h0004);
        tick();
        drive(2'b01, 4'd4, 4'd4, 4'd5);
        expect_wr(4'd5, 16'h0100);
        #1;
        chk("f2_dtx_fwd", 32'(xb_dtx), 32'h0100);
        chk("f2_dty_fwd", 32'(xb_dty), 32'h0100);
        tick();
        drive(2'b00, 4'd1, 4'd2, 4'd5);
        expect_wr(4'd5, 16'h0010);
        #1;
        chk("f3_dtx", 32'(xb_dtx), 32'h0001);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("f_r4", 32'(rf[4]), 32'h0100);
        chk("f_r5_waw", 32'(rf[5]), 32'h0010);

        // Sticky clear colliding with a new SV, then a plain clear.
        preload(4'd1, 16'h4000);
        preload(4'd2, 16'h0001);
        drive(2'b00, 4'd1, 4'd2, 4'd3);
        expect_wr(4'd3, 16'h8000);
        tick();
        req_valid = 1'b0;
        stky_clr = 1'b1;
        tick();
        stky_clr = 1'b0;
        chk("clr_set_wins", 32'(stky_sv), 1);
        chk("clr_astat_sv", 32'(astat_sv), 1);
        tick();
        stky_clr = 1'b1;
        tick();
        stky_clr = 1'b0;
        chk("clr_idle", 32'(stky_sv), 0);
        chk("clr_keeps_astat", 32'(astat_sv), 1);

        // Crossbar busy blocks issue but not the op in W.
        preload(4'd1, 16'h0001);
        preload(4'd2, 16'h0001);
        drive(2'b00, 4'd1, 4'd2, 4'd10);
        expect_wr(4'd10, 16'h0002);
        tick();
        xb_busy = 1'b1;
        drive(2'b00, 4'd1, 4'd2, 4'd11);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("busy_ready", 32'(req_ready), 0);
            chk("busy_en", 32'(ps_shf_en), 0);
            tick();
        end
        xb_busy = 1'b0;
        req_valid = 1'b0;
        tick();
        chk("busy_r10", 32'(rf[10]), 32'h0002);
        chk("busy_sv", 32'(astat_sv), 0);

        // Reset while an op with SV=1 sits in W.
        preload(4'd1, 16'h4000);
        preload(4'd7, 16'h1234);
        drive(2'b00, 4'd1, 4'd2, 4'd7);
        tick();
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rstw_wr_en", 32'(rf_wr_en), 0);
        chk("rstw_ready", 32'(req_ready), 0);
        tick();
        reset = 1'b0;
        chk("rstw_sv", 32'(astat_sv), 0);
        chk("rstw_stky", 32'(stky_sv), 0);
        tick();
        chk("rstw_r7", 32'(rf[7]), 32'h1234);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
